fp_mul_seq: RTL and testbench
=============================

Name: fp_mul_seq

Overview:
- Multi-cycle sequencer for the single-precision (IEEE-754 binary32) multiplier datapath.
- Accepts an operand pair over a valid/ready handshake and unpacks sign, exponent and mantissa.
- Adds the biased exponents and drives an iterative shift-add mantissa core, then normalizes, rounds and packs.
- Returns the result with exception flags over a second valid/ready handshake. Sits between the operand source and the FP result consumer.

Parameters:
- BITS_PER_CYCLE, 1, mantissa product bits retired per MUL cycle. Legal values: 1, 2, 3, 4. ITER = 24/BITS_PER_CYCLE.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- op_a  in  32  binary32 operand A
- op_b  in  32  binary32 operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  binary32 product
- flag_ovf  out  1  overflow to infinity
- flag_unf  out  1  underflow flushed to zero
- flag_nan  out  1  invalid operation / NaN result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0, busy=0.
- FSM states: IDLE -> MUL -> NORM -> RND -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, capture the operands and go to MUL. Inputs are ignored outside IDLE.
- Capture edge actions:
  - sign = a31 ^ b31.
  - 10-bit signed exponent E = eA + eB - 127.
  - Mantissas = {1,frac}. Exponent field 0 is treated as zero (denormals flushed).
  - Precompute special class: NaN, INF or ZERO.
- MUL: iteration counter runs 0..ITER-1, retiring BITS_PER_CYCLE bits per cycle into a 48-bit product. Leave MUL when counter==ITER-1.
- NORM: if product bit47=1, shift right 1 and E=E+1. Form 23-bit fraction, guard bit and sticky (OR of remaining bits).
- RND (priority order):
  1. NaN operand, or INF x ZERO: 0x7FC00000, flag_nan=1.
  2. INF operand: sign|0x7F800000.
  3. ZERO operand: sign|0.
  4. E>=255 after rounding: sign|0x7F800000, flag_ovf=1.
  5. E<=0: sign|0, flag_unf=1.
  6. Otherwise: pack {sign, E[7:0], frac}.
- DONE: out_valid=1. result and flags are held stable until out_ready=1, then go to IDLE with out_valid=0 on the same edge.
- Latency: fixed regardless of operand class. out_valid is high after edge ITER+3 following the acceptance edge (27 for BITS_PER_CYCLE=1).
- Throughput: one operation in flight. in_ready=0 from the acceptance edge until the DONE handshake edge.
- Flags are cleared at every acceptance.
- Reset during MUL/NORM/RND/DONE aborts the operation. No output is produced.

Optional Feature:
- FP_RNE_EN defined: round-to-nearest-even.
  - Increment when guard & (sticky | frac[0]).
  - A mantissa carry-out sets frac=0 and E=E+1, then the overflow check is re-applied.
- FP_RNE_EN undefined: truncation (round toward zero). Guard and sticky are ignored.

Decomposition:
- Package fp_mul_pkg:
  - EXP_BIAS=127, MANT_W=24, PROD_W=48, EXP_MAX=255
  - QNAN=32'h7FC00000, INF_MAG=31'h7F800000
  - FSM state enum, special-class enum
- Sub-module fp_mul_shift_add: iterative mantissa multiplier.
  - Ports: load, step, 24-bit operands, 48-bit product.
  - Controlled by the FSM counter.
- Exponent, rounding and pack logic stay in fp_mul_seq.

Test Plan:
- Basic: 0x3FC00000 x 0x40000000 (1.5 x 2.0) -> result 0x40400000, flags 0. out_valid exactly 27 edges after acceptance (BITS_PER_CYCLE=1); repeat with 2 -> 15.
- Sign and zero:
  - 0xC0000000 x 0x40400000 -> 0xC0C00000.
  - 0x00000000 x 0x40490FDB -> 0x00000000, flag_unf=0.
- Exceptions:
  - 0x7F000000 x 0x7F000000 -> 0x7F800000, flag_ovf=1.
  - 0x7F800000 x 0x00000000 -> 0x7FC00000, flag_nan=1.
  - 0x00800000 x 0x00800000 -> 0x00000000, flag_unf=1.
- Rounding: 0x3F800001 x 0x3FC00000 -> 0x3FC00001 without FP_RNE_EN, 0x3FC00002 with FP_RNE_EN.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. result and flags stay stable, in_ready=0, new in_valid is ignored. Release -> IDLE next edge, in_ready=1.
- Reset mid-operation: assert rst at MUL iteration 10 -> out_valid=0 and in_ready=1 immediately. The next operation returns the correct result with full latency.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// ============================================================================
// fp_mul_pkg : shared constants, FSM/class enums and operand classifier
//              for the sequential binary32 multiplier.
// Rev 1.0
// ============================================================================
`default_nettype none

package fp_mul_pkg;

    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 24;
    localparam int PROD_W   = 48;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [30:0] INF_MAG = 31'h7F800000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_NORM = 3'd2,
        ST_RND  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_NAN  = 2'd1,
        CLS_INF  = 2'd2,
        CLS_ZERO = 2'd3
    } cls_t;

    // Operand magnitudes only; exponent field 0 counts as zero (denormal flush).
    function automatic cls_t classify(input logic [30:0] a, input logic [30:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            return CLS_NAN;
        end else if (a_inf || b_inf) begin
            return CLS_INF;
        end else if (a_zero || b_zero) begin
            return CLS_ZERO;
        end
        return CLS_NORM;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mul_shift_add.sv
// ============================================================================
// fp_mul_shift_add : iterative radix-2^BITS_PER_CYCLE unsigned mantissa
//                    multiplier, LSB-first, multiplier shifted out of product.
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_mul_shift_add
    import fp_mul_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] mcand,
    input  logic [MANT_W-1:0] mplier,
    output logic [PROD_W-1:0] product
);

    localparam int PART_W = MANT_W + BITS_PER_CYCLE;

    logic [MANT_W-1:0] mcand_q, mcand_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [PART_W-1:0] pp [BITS_PER_CYCLE];
    logic [PART_W-1:0] partial;
    logic [PART_W-1:0] hi_sum;

    generate
        for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_pp
            assign pp[j] = prod_q[j] ? (PART_W'(mcand_q) << j) : '0;
        end
    endgenerate

    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            partial = partial + pp[j];
        end
    end

    // Upper half plus partial product never exceeds PART_W bits.
    assign hi_sum = PART_W'(prod_q[PROD_W-1:MANT_W]) + partial;

    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        if (load) begin
            mcand_d = mcand;
            prod_d  = {{MANT_W{1'b0}}, mplier};
        end else if (step) begin
            prod_d = {hi_sum, prod_q[MANT_W-1:BITS_PER_CYCLE]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign product = prod_q;

endmodule

`default_nettype wire

// File: rtl/fp_mul_seq.sv
// ============================================================================
// fp_mul_seq : multi-cycle binary32 multiplier sequencer with valid/ready I/O.
//              Define FP_RNE_EN for round-to-nearest-even (default truncates).
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        flag_nan,
    output logic        busy
);

    localparam int                 ITER     = MANT_W / BITS_PER_CYCLE;
    localparam int                 CNT_W    = 5;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ITER - 1);
    localparam logic signed [9:0]  EXP_OVF  = 10'(EXP_MAX);

    state_t             state_q, state_d;
    cls_t               cls_q, cls_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [MANT_W-1:0]  mant_a_q, mant_a_d;
    logic [MANT_W-1:0]  mant_b_q, mant_b_d;
    logic               load_pend_q, load_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [22:0]        frac_q, frac_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               nan_q, nan_d;

    logic               core_load, core_step;
    logic [PROD_W-1:0]  prod;
    logic signed [9:0]  rnd_exp;
    logic [22:0]        rnd_frac;

`ifdef FP_RNE_EN
    logic guard_q, guard_d;
    logic sticky_q, sticky_d;
    logic rnd_inc, rnd_carry;

    always_comb begin
        rnd_exp = exp_q;
        rnd_inc = guard_q & (sticky_q | frac_q[0]);
        {rnd_carry, rnd_frac} = {1'b0, frac_q} + {23'd0, rnd_inc};
        if (rnd_carry) begin
            rnd_exp = exp_q + 10'sd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
        end
    end
`else
    logic unused_prod_lsbs;
    assign unused_prod_lsbs = ^prod[22:0];

    always_comb begin
        rnd_exp  = exp_q;
        rnd_frac = frac_q;
    end
`endif

    fp_mul_shift_add #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .step    (core_step),
        .mcand   (mant_a_q),
        .mplier  (mant_b_q),
        .product (prod)
    );

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_a_d    = mant_a_q;
        mant_b_d    = mant_b_q;
        load_pend_d = load_pend_q;
        cnt_d       = cnt_q;
        frac_d      = frac_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        nan_d       = nan_q;
`ifdef FP_RNE_EN
        guard_d     = guard_q;
        sticky_d    = sticky_q;
`endif
        core_load   = 1'b0;
        core_step   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d      = op_a[31] ^ op_b[31];
                    exp_d       = {2'b00, op_a[30:23]} + {2'b00, op_b[30:23]} - 10'(EXP_BIAS);
                    mant_a_d    = {1'b1, op_a[22:0]};
                    mant_b_d    = {1'b1, op_b[22:0]};
                    cls_d       = classify(op_a[30:0], op_b[30:0]);
                    cnt_d       = '0;
                    load_pend_d = 1'b1;
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    nan_d       = 1'b0;
                    state_d     = ST_MUL;
                end
            end

            // Core loads from registered mantissas, then retires ITER steps.
            ST_MUL: begin
                if (load_pend_q) begin
                    core_load   = 1'b1;
                    load_pend_d = 1'b0;
                end else begin
                    core_step = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_NORM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_NORM: begin
                if (prod[PROD_W-1]) begin
                    frac_d   = prod[46:24];
                    exp_d    = exp_q + 10'sd1;
`ifdef FP_RNE_EN
                    guard_d  = prod[23];
                    sticky_d = |prod[22:0];
`endif
                end else begin
                    frac_d   = prod[45:23];
`ifdef FP_RNE_EN
                    guard_d  = prod[22];
                    sticky_d = |prod[21:0];
`endif
                end
                state_d = ST_RND;
            end

            ST_RND: begin
                if (cls_q == CLS_NAN) begin
                    result_d = QNAN;
                    nan_d    = 1'b1;
                end else if (cls_q == CLS_INF) begin
                    result_d = {sign_q, INF_MAG};
                end else if (cls_q == CLS_ZERO) begin
                    result_d = {sign_q, 31'd0};
                end else if (rnd_exp >= EXP_OVF) begin
                    result_d = {sign_q, INF_MAG};
                    ovf_d    = 1'b1;
                end else if (rnd_exp <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, rnd_exp[7:0], rnd_frac};
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cls_q       <= CLS_NORM;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_a_q    <= '0;
            mant_b_q    <= '0;
            load_pend_q <= 1'b0;
            cnt_q       <= '0;
            frac_q      <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            nan_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_a_q    <= mant_a_d;
            mant_b_q    <= mant_b_d;
            load_pend_q <= load_pend_d;
            cnt_q       <= cnt_d;
            frac_q      <= frac_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            nan_q       <= nan_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;
    assign flag_ovf  = ovf_q;
    assign flag_unf  = unf_q;
    assign flag_nan  = nan_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
// ============================================================================
// tb_fp_mul_seq : scoreboard bench for fp_mul_seq, BITS_PER_CYCLE 1 and 2.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp_mul_seq;

    localparam int LAT1 = 27;
    localparam int LAT2 = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [31:0] op_a, op_b;

    logic        in_ready1, out_valid1, ovf1, unf1, nan1, busy1;
    logic [31:0] result1;
    logic        in_ready2, out_valid2, ovf2, unf2, nan2, busy2;
    logic [31:0] result2;

    always #5 clk = ~clk;

    fp_mul_seq #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .flag_ovf(ovf1), .flag_unf(unf1), .flag_nan(nan1),
        .busy(busy1)
    );

    fp_mul_seq #(.BITS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2), .flag_ovf(ovf2), .flag_unf(unf2), .flag_nan(nan2),
        .busy(busy2)
    );

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;   // {ovf, unf, nan}
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic [2:0] flg,
                             input exp_t e, input int lat);
        chk({tag, " result"}, res, e.res);
        chk({tag, " flags"}, {29'd0, flg}, {29'd0, e.flg});
        if (e.chk_lat) chk({tag, " latency"}, 32'(edges - e.acc), 32'(lat));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected output: got 0x%08h expected none", result1);
            end else begin
                check_out("dut1", result1, {ovf1, unf1, nan1}, q1.pop_front(), LAT1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid2 && out_ready) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut2 unexpected output: got 0x%08h expected none", result2);
            end else begin
                check_out("dut2", result2, {ovf2, unf2, nan2}, q2.pop_front(), LAT2);
            end
        end
    end

    // Called at posedge+1; returns 1 time unit after the acceptance edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input logic [2:0] flg, input bit chk_lat);
        int   n = 0;
        exp_t e;
        while (!(in_ready1 && in_ready2) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL issue timeout: in_ready got 0 expected 1");
        end
        in_valid = 1'b1; op_a = a; op_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.res = res; e.flg = flg; e.acc = edges; e.chk_lat = chk_lat;
        q1.push_back(e);
        q2.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL drain timeout: pending %0d/%0d expected 0/0", q1.size(), q2.size());
            q1.delete(); q2.delete();
        end
    endtask

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];
    logic [2:0]  vf [8];

    initial begin
        va[0] = 32'h3FC00000; vb[0] = 32'h40000000; vr[0] = 32'h40400000; vf[0] = 3'b000;
        va[1] = 32'hC0000000; vb[1] = 32'h40400000; vr[1] = 32'hC0C00000; vf[1] = 3'b000;
        va[2] = 32'h00000000; vb[2] = 32'h40490FDB; vr[2] = 32'h00000000; vf[2] = 3'b000;
        va[3] = 32'h7F000000; vb[3] = 32'h7F000000; vr[3] = 32'h7F800000; vf[3] = 3'b100;
        va[4] = 32'h7F800000; vb[4] = 32'h00000000; vr[4] = 32'h7FC00000; vf[4] = 3'b001;
        va[5] = 32'h00800000; vb[5] = 32'h00800000; vr[5] = 32'h00000000; vf[5] = 3'b010;
`ifdef FP_RNE_EN
        va[6] = 32'h3F800001; vb[6] = 32'h3FC00000; vr[6] = 32'h3FC00002; vf[6] = 3'b000;
`else
        va[6] = 32'h3F800001; vb[6] = 32'h3FC00000; vr[6] = 32'h3FC00001; vf[6] = 3'b000;
`endif
        va[7] = 32'hFF800000; vb[7] = 32'h40000000; vr[7] = 32'hFF800000; vf[7] = 3'b000;

        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready1}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid1}, 32'd0);
        chk("reset result", result1, 32'd0);
        chk("reset flags", {29'd0, ovf1, unf1, nan1}, 32'd0);
        chk("reset busy", {31'd0, busy1}, 32'd0);
        chk("reset dut2 in_ready", {31'd0, in_ready2}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            issue(va[i], vb[i], vr[i], vf[i], 1'b1);
            chk("busy after accept", {31'd0, busy1}, 32'd1);
            drain();
        end

        // Backpressure: result held, new operands ignored while in DONE.
        out_ready = 1'b0;
        issue(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 1'b0);
        for (int n = 0; n < 60 && !out_valid1; n++) begin
            @(posedge clk); #1;
        end
        chk("bp out_valid reached", {31'd0, out_valid1}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp result stable", result1, 32'h40400000);
            chk("bp flags stable", {29'd0, ovf1, unf1, nan1}, 32'd0);
            chk("bp in_ready low", {31'd0, in_ready1}, 32'd0);
            in_valid = 1'b1; op_a = 32'h7F800000; op_b = 32'h00000000;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", {31'd0, in_ready1}, 32'd1);
        chk("bp release out_valid", {31'd0, out_valid1}, 32'd0);
        drain();

        // Abort at MUL iteration 10 via asynchronous reset.
        issue(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 1'b1);
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort out_valid", {31'd0, out_valid1}, 32'd0);
        chk("abort in_ready", {31'd0, in_ready1}, 32'd1);
        chk("abort busy", {31'd0, busy1}, 32'd0);
        chk("abort dut2 in_ready", {31'd0, in_ready2}, 32'd1);
        q1.delete(); q2.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 1'b1);
        drain();

        repeat (40) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
